// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the reaction timer: FSM state encoding and datapath widths.
package reaction_timer_pkg;

    localparam int REACT_MS_W = 14;
    localparam int DELAY_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_DELAY,
        ST_REACT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/reaction_timer_if.sv
// Player/generator/display signal bundle of the reaction timer.
interface reaction_timer_if;
    import reaction_timer_pkg::*;

    logic                  start_btn;
    logic                  react_btn;
    logic [6:0]            rand_in;
    logic                  rand_valid;
    logic                  lfsr_stop;
    logic                  led;
    logic [REACT_MS_W-1:0] react_ms;
    logic                  result_valid;
    logic                  false_start;
    logic                  timeout;

    modport master (
        output start_btn, react_btn, rand_in, rand_valid,
        input  lfsr_stop, led, react_ms, result_valid, false_start, timeout
    );

    modport slave (
        input  start_btn, react_btn, rand_in, rand_valid,
        output lfsr_stop, led, react_ms, result_valid, false_start, timeout
    );

endinterface

// File: rtl/reaction_timer_ms_tick.sv
// Millisecond tick divider: one-cycle ms_tick every TICK_DIV clocks, restartable via clear.
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic ms_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign ms_tick = (cnt_reg == LAST);

endmodule

// File: rtl/reaction_timer.sv
// Reaction-game controller: seeds a random wait from the LFSR, lights the go LED and
// measures the player's response in ms, flagging false starts and timeouts.
module reaction_timer
    import reaction_timer_pkg::*;
#(
    parameter int TICK_DIV      = 50000,
    parameter int DELAY_BASE_MS = 1000,
    parameter int DELAY_SCALE   = 16,
    parameter int MAX_REACT_MS  = 9999
) (
    input  logic             clk,
    input  logic             reset,
    reaction_timer_if.slave  bus
);

    localparam logic [REACT_MS_W-1:0] REACT_MAX  = REACT_MS_W'(MAX_REACT_MS);
    localparam logic [REACT_MS_W-1:0] REACT_LAST = REACT_MS_W'(MAX_REACT_MS - 1);

    state_t                state_reg, state_next;
    logic                  start_armed_reg, react_armed_reg;
    logic                  start_edge, react_edge;
    logic                  ms_tick, tick_clear, seed_stop, go_led;
    logic                  delay_done, react_full;
    logic [DELAY_W-1:0]    delay_cnt_reg, delay_load;
    logic [REACT_MS_W-1:0] react_cnt_reg, react_ms_reg;
    logic                  result_valid_reg, false_start_reg, timeout_reg;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .clear   (tick_clear),
        .ms_tick (ms_tick)
    );

    // The armed bits record "button seen low last cycle"; clearing them on reset
    // means a button already held through reset never counts as a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_armed_reg <= 1'b0;
            react_armed_reg <= 1'b0;
        end else begin
            start_armed_reg <= ~bus.start_btn;
            react_armed_reg <= ~bus.react_btn;
        end
    end

    assign start_edge = bus.start_btn & start_armed_reg;
    assign react_edge = bus.react_btn & react_armed_reg;
    assign delay_load = DELAY_W'(DELAY_BASE_MS) + DELAY_W'(bus.rand_in) * DELAY_W'(DELAY_SCALE);
    assign delay_done = ms_tick && (delay_cnt_reg == DELAY_W'(1));
    assign react_full = ms_tick && (react_cnt_reg == REACT_LAST);

    always_ff @(posedge clk) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start_edge) state_next = ST_SEED;
            ST_SEED:  if (bus.rand_valid) state_next = ST_DELAY;
            ST_DELAY: if (react_edge) state_next = ST_DONE;
                      else if (delay_done) state_next = ST_REACT;
            ST_REACT: if (react_edge || react_full) state_next = ST_DONE;
            ST_DONE:  if (start_edge) state_next = ST_SEED;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        seed_stop  = (state_reg == ST_SEED);
        go_led     = (state_reg == ST_REACT);
        tick_clear = (state_next != state_reg) &&
                     (state_next == ST_DELAY || state_next == ST_REACT);
    end

    // A press always takes priority over a tick arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            delay_cnt_reg    <= '0;
            react_cnt_reg    <= '0;
            react_ms_reg     <= '0;
            result_valid_reg <= 1'b0;
            false_start_reg  <= 1'b0;
            timeout_reg      <= 1'b0;
        end else begin
            result_valid_reg <= 1'b0;
            case (state_reg)
                ST_SEED: begin
                    if (bus.rand_valid) begin
                        delay_cnt_reg   <= delay_load;
                        false_start_reg <= 1'b0;
                        timeout_reg     <= 1'b0;
                    end
                end
                ST_DELAY: begin
                    if (react_edge) begin
                        false_start_reg <= 1'b1;
                    end else if (ms_tick) begin
                        delay_cnt_reg <= delay_cnt_reg - 1'b1;
                        if (delay_done) react_cnt_reg <= '0;
                    end
                end
                ST_REACT: begin
                    if (react_edge) begin
                        react_ms_reg     <= react_cnt_reg;
                        result_valid_reg <= 1'b1;
                    end else if (ms_tick) begin
                        react_cnt_reg <= react_cnt_reg + 1'b1;
                        if (react_full) begin
                            react_ms_reg     <= REACT_MAX;
                            timeout_reg      <= 1'b1;
                            result_valid_reg <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.lfsr_stop    = seed_stop;
    assign bus.led          = go_led;
    assign bus.react_ms     = react_ms_reg;
    assign bus.result_valid = result_valid_reg;
    assign bus.false_start  = false_start_reg;
    assign bus.timeout      = timeout_reg;

endmodule

// File: tb/tb_reaction_timer.sv
// Scenario bench for reaction_timer with small timing parameters; results are
// predicted into a scoreboard queue and checked when result_valid pulses.
module tb_reaction_timer;

    localparam int TICK_DIV      = 4;
    localparam int DELAY_BASE_MS = 2;
    localparam int DELAY_SCALE   = 1;
    localparam int MAX_REACT_MS  = 10;

    typedef struct packed {
        logic [13:0] ms;
        logic        to;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];
    exp_t mon_exp;
    logic rv_prev = 1'b0;

    reaction_timer_if bus();

    reaction_timer #(
        .TICK_DIV      (TICK_DIV),
        .DELAY_BASE_MS (DELAY_BASE_MS),
        .DELAY_SCALE   (DELAY_SCALE),
        .MAX_REACT_MS  (MAX_REACT_MS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    // Scoreboard consumer: every result pulse must be single-cycle and predicted.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) begin
                compared++;
                if (rv_prev !== 1'b0) begin
                    mismatched++;
                    $display("FAIL result_pulse_width: result_valid high on consecutive cycles, required one cycle");
                end
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_result: result_valid pulse with react_ms=%0d timeout=%0b, none expected",
                             bus.react_ms, bus.timeout);
                end else begin
                    mon_exp = sb.pop_front();
                    if (bus.react_ms !== mon_exp.ms || bus.timeout !== mon_exp.to) begin
                        mismatched++;
                        $display("FAIL result_value: react_ms=%0d timeout=%0b, required react_ms=%0d timeout=%0b",
                                 bus.react_ms, bus.timeout, mon_exp.ms, mon_exp.to);
                    end
                end
            end
            rv_prev = bus.result_valid;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge just after the capture edge.
    task automatic start_round(input logic [6:0] v, output logic stop_seed, output logic stop_after);
        bus.start_btn = 1'b1;
        @(negedge clk);
        stop_seed      = bus.lfsr_stop;
        bus.start_btn  = 1'b0;
        bus.rand_in    = v;
        bus.rand_valid = 1'b1;
        @(negedge clk);
        stop_after     = bus.lfsr_stop;
        bus.rand_valid = 1'b0;
    endtask

    task automatic wait_led(output int k);
        k = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (bus.led === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic wait_result(output int k);
        k = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [18:0] outs;
        reset          = 1'b1;
        bus.start_btn  = 1'b1;
        bus.react_btn  = 1'b0;
        bus.rand_in    = 7'd0;
        bus.rand_valid = 1'b0;
        step(3);
        outs = {bus.lfsr_stop, bus.led, bus.react_ms, bus.result_valid, bus.false_start, bus.timeout};
        compared++;
        if (outs !== 19'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: outputs=%h, required 0", outs);
        end
        reset = 1'b0;
        step(5);
        compared++;
        if (bus.lfsr_stop !== 1'b0 || bus.led !== 1'b0) begin
            mismatched++;
            $display("FAIL held_start_ignored: lfsr_stop=%0b led=%0b, required 0 0", bus.lfsr_stop, bus.led);
        end
        bus.start_btn = 1'b0;
        step(1);
        $display("test_reset: done");
    endtask

    task automatic test_basic_round();
        logic s1, s2;
        int   k;
        start_round(7'd3, s1, s2);
        compared++;
        if (s1 !== 1'b1 || s2 !== 1'b0) begin
            mismatched++;
            $display("FAIL lfsr_stop_window: in SEED=%0b after capture=%0b, required 1 0", s1, s2);
        end
        wait_led(k);
        compared++;
        if (k != (DELAY_BASE_MS + 3 * DELAY_SCALE) * TICK_DIV) begin
            mismatched++;
            $display("FAIL led_latency: %0d cycles, required %0d", k, (DELAY_BASE_MS + 3 * DELAY_SCALE) * TICK_DIV);
        end
        step(7 * TICK_DIV + 1);
        bus.react_btn = 1'b1;
        sb.push_back(exp_t'({14'd7, 1'b0}));
        step(1);
        compared++;
        if (bus.led !== 1'b0 || bus.result_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL react_response: led=%0b result_valid=%0b, required 0 1", bus.led, bus.result_valid);
        end
        bus.react_btn = 1'b0;
        step(1);
        compared++;
        if (bus.result_valid !== 1'b0 || bus.react_ms !== 14'd7) begin
            mismatched++;
            $display("FAIL result_held: result_valid=%0b react_ms=%0d, required 0 7", bus.result_valid, bus.react_ms);
        end
        $display("test_basic_round: done, react_ms=%0d", bus.react_ms);
    endtask

    task automatic test_false_start();
        logic s1, s2;
        start_round(7'd0, s1, s2);
        step(2 * TICK_DIV - 1);
        bus.react_btn = 1'b1;
        step(1);
        compared++;
        if (bus.false_start !== 1'b1 || bus.led !== 1'b0) begin
            mismatched++;
            $display("FAIL false_start_flag: false_start=%0b led=%0b, required 1 0", bus.false_start, bus.led);
        end
        bus.react_btn = 1'b0;
        step(10);
        compared++;
        if (bus.false_start !== 1'b1 || bus.led !== 1'b0) begin
            mismatched++;
            $display("FAIL false_start_hold: false_start=%0b led=%0b, required 1 0", bus.false_start, bus.led);
        end
        $display("test_false_start: done");
    endtask

    task automatic test_timeout();
        logic s1, s2;
        int   k;
        start_round(7'd1, s1, s2);
        compared++;
        if (bus.false_start !== 1'b0 || s1 !== 1'b1) begin
            mismatched++;
            $display("FAIL false_start_clear: false_start=%0b lfsr_stop_seed=%0b, required 0 1", bus.false_start, s1);
        end
        wait_led(k);
        compared++;
        if (k != (DELAY_BASE_MS + DELAY_SCALE) * TICK_DIV) begin
            mismatched++;
            $display("FAIL led_latency_r1: %0d cycles, required %0d", k, (DELAY_BASE_MS + DELAY_SCALE) * TICK_DIV);
        end
        sb.push_back(exp_t'({14'(MAX_REACT_MS), 1'b1}));
        wait_result(k);
        compared++;
        if (k != MAX_REACT_MS * TICK_DIV) begin
            mismatched++;
            $display("FAIL timeout_latency: %0d cycles, required %0d", k, MAX_REACT_MS * TICK_DIV);
        end
        compared++;
        if (bus.timeout !== 1'b1 || bus.led !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_flag: timeout=%0b led=%0b, required 1 0", bus.timeout, bus.led);
        end
        step(2);
        $display("test_timeout: done, react_ms=%0d", bus.react_ms);
    endtask

    task automatic test_coincident_tick();
        logic s1, s2;
        int   k;
        start_round(7'd0, s1, s2);
        compared++;
        if (bus.timeout !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_clear: timeout=%0b, required 0", bus.timeout);
        end
        wait_led(k);
        step(5 * TICK_DIV - 1);
        bus.react_btn = 1'b1;
        sb.push_back(exp_t'({14'd4, 1'b0}));
        step(1);
        compared++;
        if (bus.led !== 1'b0) begin
            mismatched++;
            $display("FAIL coincident_led: led=%0b, required 0", bus.led);
        end
        bus.react_btn = 1'b0;
        step(2);
        $display("test_coincident_tick: done, react_ms=%0d", bus.react_ms);
    endtask

    task automatic test_reset_mid_round();
        logic s1, s2;
        int   k;
        start_round(7'd0, s1, s2);
        wait_led(k);
        compared++;
        if (k != DELAY_BASE_MS * TICK_DIV) begin
            mismatched++;
            $display("FAIL led_latency_r0: %0d cycles, required %0d", k, DELAY_BASE_MS * TICK_DIV);
        end
        step(3);
        reset = 1'b1;
        step(1);
        compared++;
        if (bus.led !== 1'b0 || bus.lfsr_stop !== 1'b0 || bus.react_ms !== 14'd0) begin
            mismatched++;
            $display("FAIL mid_round_reset: led=%0b lfsr_stop=%0b react_ms=%0d, required 0 0 0",
                     bus.led, bus.lfsr_stop, bus.react_ms);
        end
        reset = 1'b0;
        step(2);
        bus.react_btn = 1'b1;
        step(20);
        compared++;
        if (bus.led !== 1'b0 || bus.react_ms !== 14'd0) begin
            mismatched++;
            $display("FAIL idle_after_reset: led=%0b react_ms=%0d, required 0 0", bus.led, bus.react_ms);
        end
        bus.react_btn = 1'b0;
        step(2);
        $display("test_reset_mid_round: done");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_round();
        test_false_start();
        test_timeout();
        test_coincident_tick();
        test_reset_mid_round();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
